// File: rtl/adder_switch_pkg.sv
// adder_switch_pkg: switch command codes, config word layout and FSM encodings for adder_switch_cfg_sched
package adder_switch_pkg;

    localparam logic [2:0] CMD_NA0   = 3'b000;
    localparam logic [2:0] CMD_NA1   = 3'b001;
    localparam logic [2:0] CMD_ADD   = 3'b010;
    localparam logic [2:0] CMD_VN_L  = 3'b011;
    localparam logic [2:0] CMD_VN_R  = 3'b100;
    localparam logic [2:0] CMD_VN_LR = 3'b101;

    // Config word is {add_en, cmd, sel}, sel in the low bits.
    localparam int CFG_CMD_W   = 3;
    localparam int CFG_SEL_W   = 2;
    localparam int CFG_SEL_LSB = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    function automatic logic cmd_issues(input logic [CFG_CMD_W-1:0] cmd);
        return cmd inside {CMD_ADD, CMD_VN_L, CMD_VN_R, CMD_VN_LR};
    endfunction

    function automatic logic cmd_no_add(input logic [CFG_CMD_W-1:0] cmd);
        return cmd inside {CMD_NA0, CMD_NA1};
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// valid_delay_line: per-beat valid shift register tapped at 1 or DEPTH cycles, with an empty flag for the tap in use
module valid_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_valid,
    input  logic i_tap_full,
    output logic o_valid,
    output logic o_empty
);

    logic [DEPTH-1:0] sr_d, sr_q;

    always_comb begin
        sr_d    = '0;
        sr_d[0] = i_valid;
        for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= sr_d;
    end

    // The short tap only ever reads stage 0, so only it decides emptiness.
    assign o_valid = i_tap_full ? sr_q[DEPTH-1] : sr_q[0];
    assign o_empty = i_tap_full ? ~|sr_q : ~sr_q[0];

endmodule

// File: rtl/adder_switch_cfg_sched.sv
// adder_switch_cfg_sched: shadow/active config banks and beat sequencing for a row of adder switches.
// Define CFG_CHECK_EN to drop illegal config writes and raise a sticky o_cfg_err.
module adder_switch_cfg_sched
    import adder_switch_pkg::*;
#(
    parameter int  NUM_SW  = 8,
    parameter int  CMD_W   = CFG_CMD_W,
    parameter int  SEL_W   = CFG_SEL_W,
    parameter int  ADD_LAT = 2,
    parameter int  CNT_W   = 16,
    localparam int IDX_W   = $clog2(NUM_SW),
    localparam int CFG_W   = 1 + CMD_W + SEL_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_cfg_valid,
    output logic                    o_cfg_ready,
    input  logic [IDX_W-1:0]        i_cfg_idx,
    input  logic [CFG_W-1:0]        i_cfg_word,
    input  logic                    i_start,
    input  logic [CNT_W-1:0]        i_num_beats,
    input  logic                    i_data_valid,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [NUM_SW-1:0]       o_sw_valid,
    output logic [NUM_SW-1:0]       o_sw_add_en,
    output logic [NUM_SW*CMD_W-1:0] o_sw_cmd,
    output logic [NUM_SW*SEL_W-1:0] o_sw_sel,
    output logic                    o_res_valid,
    output logic                    o_cfg_err
);

    localparam int CMD_LSB    = CFG_SEL_LSB + SEL_W;
    localparam int ADD_EN_BIT = CMD_LSB + CMD_W;

    logic [1:0]                   state_d, state_q;
    logic [CNT_W-1:0]             cnt_d, cnt_q;
    logic [NUM_SW-1:0][CFG_W-1:0] shadow_d, shadow_q;
    logic [NUM_SW-1:0][CFG_W-1:0] active_d, active_q;
    logic                         zdone_d, zdone_q;
    logic [NUM_SW-1:0]            sw_iss;
    logic                         cfg_acc, cfg_bad, issue, lat_full, pipe_empty;

    assign o_cfg_ready = state_q == ST_IDLE;
    assign o_busy      = state_q != ST_IDLE;
    assign cfg_acc     = i_cfg_valid && o_cfg_ready;
    assign issue       = state_q == ST_RUN && i_data_valid && cnt_q != '0;

`ifdef CFG_CHECK_EN
    logic err_q;
    assign cfg_bad = (cmd_no_add(i_cfg_word[CMD_LSB +: CMD_W]) && i_cfg_word[ADD_EN_BIT])
                     || int'(i_cfg_idx) >= NUM_SW;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_q | (cfg_acc & cfg_bad);
    end
    assign o_cfg_err = err_q;
`else
    assign cfg_bad   = 1'b0;
    assign o_cfg_err = 1'b0;
`endif

    always_comb begin
        sw_iss      = '0;
        o_sw_add_en = '0;
        o_sw_cmd    = '0;
        o_sw_sel    = '0;
        for (int k = 0; k < NUM_SW; k++) begin
            sw_iss[k]                   = cmd_issues(active_q[k][CMD_LSB +: CMD_W]);
            o_sw_add_en[k]              = active_q[k][ADD_EN_BIT];
            o_sw_cmd[k*CMD_W +: CMD_W]  = active_q[k][CMD_LSB +: CMD_W];
            o_sw_sel[k*SEL_W +: SEL_W]  = active_q[k][CFG_SEL_LSB +: SEL_W];
        end
    end

    assign o_sw_valid = {NUM_SW{issue}} & sw_iss;
    // Only issuing switches that use the FP adder stretch the result latency.
    assign lat_full   = |(sw_iss & o_sw_add_en);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        zdone_d  = 1'b0;
        if (cfg_acc && !cfg_bad) shadow_d[i_cfg_idx] = i_cfg_word;
        // Commit reads shadow_q, so a same-cycle write lands only for the next job.
        if (state_q == ST_IDLE && i_start) begin
            active_d = shadow_q;
            cnt_d    = i_num_beats;
            zdone_d  = i_num_beats == '0;
            state_d  = zdone_d ? ST_IDLE : ST_RUN;
        end
        if (issue) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = ST_DRAIN;
        end
        if (state_q == ST_DRAIN && pipe_empty) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            zdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            zdone_q  <= zdone_d;
        end
    end

    assign o_done = zdone_q | (state_q == ST_DRAIN && pipe_empty);

    valid_delay_line #(
        .DEPTH(ADD_LAT)
    ) u_dly (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (issue),
        .i_tap_full(lat_full),
        .o_valid   (o_res_valid),
        .o_empty   (pipe_empty)
    );

endmodule
